// File: rtl/ddr2_arb_pkg.sv
// Shared constants for the DDR2 MIG application-port arbiter: FSM encoding,
// MIG command codes and the grant-history encoding.
package ddr2_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  localparam logic GNT_WR = 1'b0;
  localparam logic GNT_RD = 1'b1;

  // Wide enough for the largest supported read depth (15).
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/ddr2_rd_tracker.sv
// Read-return bookkeeping: outstanding-read counter, sticky underflow flag
// and the one-cycle rd_data/rd_valid retiming register.
module ddr2_rd_tracker
  import ddr2_arb_pkg::*;
#(
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              ret_valid,
  input  logic [DATA_W-1:0] ret_data,
  output logic [CNT_W-1:0]  outstanding,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              underflow
);

  logic [CNT_W-1:0] outstanding_n;
  logic             underflow_n;

  // A return with nothing outstanding is flagged and otherwise ignored.
  always_comb begin
    outstanding_n = outstanding;
    underflow_n   = underflow;
    if (ret_valid && (outstanding == '0)) begin
      underflow_n = 1'b1;
      if (inc) outstanding_n = CNT_W'(1);
    end else if (inc && !ret_valid) begin
      outstanding_n = outstanding + CNT_W'(1);
    end else if (!inc && ret_valid) begin
      outstanding_n = outstanding - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      underflow   <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
    end else begin
      outstanding <= outstanding_n;
      underflow   <= underflow_n;
      rd_valid    <= ret_valid;
      if (ret_valid) rd_data <= ret_data;
    end
  end

endmodule

// File: rtl/ddr2_app_arbiter.sv
// Round-robin arbiter between one write and one read requester onto a
// DDR2 MIG application interface, with a bounded number of reads in flight.
module ddr2_app_arbiter
  import ddr2_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 27,
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned MAX_RD_OUT = 4
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              calib_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_underflow,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  output logic [DATA_W-1:0] app_wdf_data,
  input  logic              app_rdy,
  input  logic              app_wdf_rdy,
  input  logic              app_rd_data_valid,
  input  logic [DATA_W-1:0] app_rd_data
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_RD_OUT);

  logic [1:0]        state, state_n;
  logic              last_gnt, last_gnt_n;
  logic              en_n, wren_n;
  logic [2:0]        cmd_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n;
  logic [CNT_W-1:0]  outstanding;
  logic              wr_elig, rd_elig, gnt_wr, gnt_rd;

  // Eligibility and round-robin tie-break evaluated in IDLE.
  assign wr_elig = calib_done && wr_req;
  assign rd_elig = calib_done && rd_req && (outstanding < MAX_CNT);
  assign gnt_wr  = wr_elig && (!rd_elig || (last_gnt == GNT_RD));
  assign gnt_rd  = rd_elig && !gnt_wr;

  assign app_wdf_end = app_wdf_wren;

  always_comb begin
    state_n    = state;
    last_gnt_n = last_gnt;
    en_n       = app_en;
    wren_n     = app_wdf_wren;
    cmd_n      = app_cmd;
    addr_n     = app_addr;
    wdata_n    = app_wdf_data;
    wr_ack     = 1'b0;
    rd_ack     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (gnt_wr) begin
          state_n    = ST_WR;
          last_gnt_n = GNT_WR;
          en_n       = 1'b1;
          wren_n     = 1'b1;
          cmd_n      = CMD_WRITE;
          addr_n     = wr_addr;
          wdata_n    = wr_data;
        end else if (gnt_rd) begin
          state_n    = ST_RD;
          last_gnt_n = GNT_RD;
          en_n       = 1'b1;
          cmd_n      = CMD_READ;
          addr_n     = rd_addr;
        end
      end
      ST_WR: begin
        // Command and data retire independently; ack when both are gone.
        en_n   = app_en && !app_rdy;
        wren_n = app_wdf_wren && !app_wdf_rdy;
        if (!en_n && !wren_n) begin
          wr_ack  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_RD: begin
        if (app_rdy) begin
          en_n    = 1'b0;
          cmd_n   = CMD_WRITE;
          rd_ack  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        en_n    = 1'b0;
        wren_n  = 1'b0;
        cmd_n   = CMD_WRITE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      last_gnt     <= GNT_RD;
      app_en       <= 1'b0;
      app_wdf_wren <= 1'b0;
      app_cmd      <= CMD_WRITE;
      app_addr     <= '0;
      app_wdf_data <= '0;
    end else begin
      state        <= state_n;
      last_gnt     <= last_gnt_n;
      app_en       <= en_n;
      app_wdf_wren <= wren_n;
      app_cmd      <= cmd_n;
      app_addr     <= addr_n;
      app_wdf_data <= wdata_n;
    end
  end

  ddr2_rd_tracker #(
    .DATA_W (DATA_W)
  ) u_rd_tracker (
    .clk         (clk_in),
    .rst_n       (rst_n),
    .inc         (rd_ack),
    .ret_valid   (app_rd_data_valid),
    .ret_data    (app_rd_data),
    .outstanding (outstanding),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .underflow   (rd_underflow)
  );

endmodule

// File: tb/tb_ddr2_app_arbiter.sv
// Bench for ddr2_app_arbiter: arbitration vector table, directed handshake
// corner cases and random traffic against a transaction-level model.
module tb_ddr2_app_arbiter;
  import ddr2_arb_pkg::*;

  localparam int unsigned ADDR_W     = 27;
  localparam int unsigned DATA_W     = 128;
  localparam int unsigned MAX_RD_OUT = 4;

  logic              clk_in = 1'b0;
  logic              rst_n, calib_done, wr_req, rd_req;
  logic              app_rdy, app_wdf_rdy, app_rd_data_valid;
  logic [ADDR_W-1:0] wr_addr, rd_addr, app_addr;
  logic [DATA_W-1:0] wr_data, app_rd_data, rd_data, app_wdf_data;
  logic              wr_ack, rd_ack, rd_valid, rd_underflow;
  logic              app_en, app_wdf_wren, app_wdf_end;
  logic [2:0]        app_cmd;

  int checks   = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  ddr2_app_arbiter #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .MAX_RD_OUT (MAX_RD_OUT)
  ) dut (
    .clk_in (clk_in), .rst_n (rst_n), .calib_done (calib_done),
    .wr_req (wr_req), .wr_addr (wr_addr), .wr_data (wr_data), .wr_ack (wr_ack),
    .rd_req (rd_req), .rd_addr (rd_addr), .rd_ack (rd_ack),
    .rd_data (rd_data), .rd_valid (rd_valid), .rd_underflow (rd_underflow),
    .app_en (app_en), .app_cmd (app_cmd), .app_addr (app_addr),
    .app_wdf_wren (app_wdf_wren), .app_wdf_end (app_wdf_end),
    .app_wdf_data (app_wdf_data), .app_rdy (app_rdy), .app_wdf_rdy (app_wdf_rdy),
    .app_rd_data_valid (app_rd_data_valid), .app_rd_data (app_rd_data)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [DATA_W-1:0] act,
                      input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_in);
  endtask

  task automatic clear_inputs();
    calib_done = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data_valid = 1'b0;
    app_rd_data = '0; wr_addr = '0; rd_addr = '0; wr_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    step();
    rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string name);
    chkw({name, "_ctl"}, DATA_W'({app_en, app_cmd, app_wdf_wren, app_wdf_end,
                                  wr_ack, rd_ack, rd_valid, rd_underflow}), '0);
    chkw({name, "_addr"}, DATA_W'(app_addr), '0);
    chkw({name, "_data"}, app_wdf_data | rd_data, '0);
  endtask

  typedef struct {
    logic       cal, wr, rd;
    logic       exp_en;
    logic [2:0] exp_cmd;
    logic       exp_wren;
    logic [1:0] sel;  // 0: no grant, 1: write address, 2: read address
  } vec_t;

  vec_t vecs[6];

  localparam logic [ADDR_W-1:0] A_WR = 27'h1234567;
  localparam logic [ADDR_W-1:0] A_RD = 27'h0abcdef;
  localparam logic [DATA_W-1:0] D_WR = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam logic [DATA_W-1:0] D_A5 = {16{8'hA5}};

  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_prev;
  int                n, en_cnt, wren_cnt, ack_at, ack_cnt;
  logic              got, seen;

  // Random-phase model state
  logic              wr_pend, rd_pend, wc, wd, prev_v, cacc, dacc, exp_wack, exp_rack;
  logic [DATA_W-1:0] prev_d;
  int                mout, wr_age, rd_age, nwr, nrd, timeouts;

  initial begin
    #400000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, CMD_WRITE, 1'b0, 2'd0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, CMD_WRITE, 1'b0, 2'd0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, CMD_WRITE, 1'b1, 2'd1};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, CMD_READ,  1'b0, 2'd2};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, CMD_WRITE, 1'b1, 2'd1};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, CMD_WRITE, 1'b0, 2'd0};

    rst_n = 1'b0;
    clear_inputs();
    #2;
    chk_all_zero("reset_async");
    do_reset();
    mid();
    chk_all_zero("reset_state");
    step();

    // Arbitration table: one grant decision from a fresh reset.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      calib_done = vecs[i].cal; wr_req = vecs[i].wr; rd_req = vecs[i].rd;
      wr_addr = A_WR; rd_addr = A_RD; wr_data = D_WR;
      mid();
      chk1($sformatf("vec%0d_grant_cycle_en", i), app_en, 1'b0);
      step();
      mid();
      exp_addr = (vecs[i].sel == 2'd1) ? A_WR : (vecs[i].sel == 2'd2) ? A_RD : '0;
      chk1($sformatf("vec%0d_en", i), app_en, vecs[i].exp_en);
      chkw($sformatf("vec%0d_cmd", i), DATA_W'(app_cmd), DATA_W'(vecs[i].exp_cmd));
      chk1($sformatf("vec%0d_wren", i), app_wdf_wren, vecs[i].exp_wren);
      chk1($sformatf("vec%0d_wend", i), app_wdf_end, vecs[i].exp_wren);
      chkw($sformatf("vec%0d_addr", i), DATA_W'(app_addr), DATA_W'(exp_addr));
      chkw($sformatf("vec%0d_wdata", i), app_wdf_data, vecs[i].exp_wren ? D_WR : '0);
      step();
    end

    // Tie after reset: write first, then read.
    do_reset();
    calib_done = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    wr_addr = A_WR; rd_addr = A_RD; wr_data = D_WR; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    mid(); chk1("tie_idle_en", app_en, 1'b0);
    step(); mid();
    chkw("tie_first_cmd", DATA_W'({app_en, app_cmd}), DATA_W'({1'b1, CMD_WRITE}));
    chk1("tie_wr_ack", wr_ack, 1'b1);
    chk1("tie_no_rd_ack", rd_ack, 1'b0);
    step(); wr_req = 1'b0;
    mid(); chk1("tie_gap_en", app_en, 1'b0);
    step(); mid();
    chkw("tie_second_cmd", DATA_W'({app_en, app_cmd}), DATA_W'({1'b1, CMD_READ}));
    chkw("tie_rd_addr", DATA_W'(app_addr), DATA_W'(A_RD));
    chk1("tie_rd_ack", rd_ack, 1'b1);
    step(); rd_req = 1'b0;
    mid(); chkw("tie_idle_after", DATA_W'({app_en, app_cmd}), '0);
    step();

    // Write data held off for three cycles.
    do_reset();
    calib_done = 1'b1; wr_req = 1'b1; wr_addr = A_WR; wr_data = D_WR; app_rdy = 1'b1;
    en_cnt = 0; wren_cnt = 0; ack_at = 0; ack_cnt = 0;
    for (int c = 0; c < 7; c++) begin
      app_wdf_rdy = (c == 4);
      mid();
      en_cnt   += int'(app_en);
      wren_cnt += int'(app_wdf_wren);
      if (wr_ack) begin ack_at = c; ack_cnt++; end
      step();
      if (ack_cnt != 0) wr_req = 1'b0;
    end
    chkw("wdf_stall_en_cycles", DATA_W'(en_cnt), DATA_W'(1));
    chkw("wdf_stall_wren_cycles", DATA_W'(wren_cnt), DATA_W'(4));
    chkw("wdf_stall_ack_cycle", DATA_W'(ack_at), DATA_W'(4));
    chkw("wdf_stall_ack_count", DATA_W'(ack_cnt), DATA_W'(1));

    // Read depth limit: five reads, no returns.
    do_reset();
    calib_done = 1'b1; app_rdy = 1'b1; rd_req = 1'b1; rd_addr = A_RD;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      mid();
      if (rd_ack) n++;
      step();
    end
    chkw("rd_limit_acks", DATA_W'(n), DATA_W'(MAX_RD_OUT));
    mid(); chk1("rd_limit_stalled_en", app_en, 1'b0);
    step();
    app_rd_data_valid = 1'b1; app_rd_data = D_A5;
    step(); app_rd_data_valid = 1'b0; app_rd_data = '0;
    mid();
    chk1("ret_a5_valid", rd_valid, 1'b1);
    chkw("ret_a5_data", rd_data, D_A5);
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      mid();
      if (rd_ack) got = 1'b1;
      step();
    end
    rd_req = 1'b0;
    chk1("rd_limit_fifth_ack", got, 1'b1);

    // Drain four in-order returns, then one extra return.
    exp_prev = '0;
    for (int i = 0; i <= 4; i++) begin
      app_rd_data_valid = (i < 4);
      app_rd_data = {4{32'hC0DE0000 + 32'(i)}};
      mid();
      if (i > 0) begin
        chk1($sformatf("ret%0d_valid", i - 1), rd_valid, 1'b1);
        chkw($sformatf("ret%0d_data", i - 1), rd_data, exp_prev);
      end
      exp_prev = app_rd_data;
      step();
    end
    app_rd_data_valid = 1'b0;
    mid(); chk1("ret_gap_valid", rd_valid, 1'b0);
    chk1("underflow_clear", rd_underflow, 1'b0);
    step();
    app_rd_data_valid = 1'b1; app_rd_data = D_A5;
    step(); app_rd_data_valid = 1'b0;
    mid(); chk1("underflow_set", rd_underflow, 1'b1);
    step(); step(); step();
    mid(); chk1("underflow_sticky", rd_underflow, 1'b1);
    step();

    // No grant before calibration completes.
    do_reset();
    wr_req = 1'b1; wr_addr = A_WR; wr_data = D_WR; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      mid(); seen = seen | app_en | wr_ack;
      step();
    end
    chk1("calib_blocks", seen, 1'b0);
    calib_done = 1'b1;
    step(); mid();
    chk1("calib_grant_en", app_en, 1'b1);
    chk1("calib_grant_ack", wr_ack, 1'b1);
    step(); wr_req = 1'b0;

    // Reset in the middle of a write.
    do_reset();
    calib_done = 1'b1; wr_req = 1'b1; wr_addr = A_WR; wr_data = D_WR;
    step(); mid();
    chk1("midrst_in_wr", app_en & app_wdf_wren, 1'b1);
    #1 rst_n = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    #1 chk_all_zero("midrst_outputs");
    step();
    chk1("midrst_no_ack", wr_ack, 1'b0);
    rst_n = 1'b1; calib_done = 1'b1; wr_addr = A_RD; wr_data = D_A5;
    mid(); chk1("midrst_idle", app_en | wr_ack, 1'b0);
    step(); mid();
    chkw("midrst_next_addr", DATA_W'(app_addr), DATA_W'(A_RD));
    chkw("midrst_next_data", app_wdf_data, D_A5);
    chk1("midrst_next_ack", wr_ack, 1'b1);
    step(); wr_req = 1'b0;

    // Random traffic against a transaction-level model.
    do_reset();
    calib_done = 1'b1;
    wr_pend = 1'b0; rd_pend = 1'b0; wc = 1'b0; wd = 1'b0; prev_v = 1'b0; prev_d = '0;
    mout = 0; wr_age = 0; rd_age = 0; nwr = 0; nrd = 0; timeouts = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!wr_pend && $urandom_range(0, 3) == 0) begin
        wr_pend = 1'b1; wc = 1'b0; wd = 1'b0; wr_age = 0;
        wr_addr = ADDR_W'($urandom);
        wr_data = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!rd_pend && $urandom_range(0, 2) == 0) begin
        rd_pend = 1'b1; rd_age = 0;
        rd_addr = ADDR_W'($urandom);
      end
      wr_req = wr_pend; rd_req = rd_pend;
      app_rdy     = ($urandom_range(0, 3) != 0);
      app_wdf_rdy = ($urandom_range(0, 3) != 0);
      app_rd_data_valid = (mout > 0) && ($urandom_range(0, 4) == 0);
      app_rd_data = {$urandom, $urandom, $urandom, $urandom};
      if (app_rd_data_valid) mout--;
      mid();
      cacc = app_en && app_rdy;
      dacc = app_wdf_wren && app_wdf_rdy;
      exp_rack = 1'b0;
      if (cacc && app_cmd == CMD_WRITE) begin
        chk1("rnd_wcmd_wanted", wr_pend && !wc, 1'b1);
        chkw("rnd_wcmd_addr", DATA_W'(app_addr), DATA_W'(wr_addr));
        wc = 1'b1;
      end else if (cacc && app_cmd == CMD_READ) begin
        chk1("rnd_rcmd_wanted", rd_pend, 1'b1);
        chkw("rnd_rcmd_addr", DATA_W'(app_addr), DATA_W'(rd_addr));
        chk1("rnd_rd_depth", mout < MAX_RD_OUT, 1'b1);
        mout++;
        exp_rack = rd_pend;
      end
      if (dacc) begin
        chk1("rnd_wdata_wanted", wr_pend && !wd, 1'b1);
        chkw("rnd_wdata", app_wdf_data, wr_data);
        wd = 1'b1;
      end
      exp_wack = wr_pend && wc && wd;
      chk1("rnd_wr_ack", wr_ack, exp_wack);
      chk1("rnd_rd_ack", rd_ack, exp_rack);
      chk1("rnd_rd_valid", rd_valid, prev_v);
      if (prev_v) chkw("rnd_rd_data", rd_data, prev_d);
      prev_v = app_rd_data_valid;
      prev_d = app_rd_data;
      if (exp_wack) begin wr_pend = 1'b0; nwr++; end
      if (exp_rack) begin rd_pend = 1'b0; nrd++; end
      if (wr_pend) wr_age++;
      if (rd_pend) rd_age++;
      if (wr_age > 100) begin timeouts++; wr_pend = 1'b0; wr_age = 0; end
      if (rd_age > 200) begin timeouts++; rd_pend = 1'b0; rd_age = 0; end
      step();
    end
    chkw("rnd_timeouts", DATA_W'(timeouts), '0);
    chk1("rnd_progress", (nwr > 100) && (nrd > 100), 1'b1);
    chk1("rnd_no_underflow", rd_underflow, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr2_app_arbiter.md
DDR2_APP_ARBITER -- requirements
Module: ddr2_app_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 27, MIG app_addr width.
REQ-002 SHALL have parameter DATA_W, 128, MIG app data width.
REQ-003 SHALL have parameter MAX_RD_OUT, 4, maximum reads issued but not yet returned (range 1..15).
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL provide these ports:
- clk_in  in  1  MIG ui_clk; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- calib_done  in  1  MIG init_calib_complete.
- wr_req  in  1  write request; level, held until wr_ack.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_ack  out  1  one-cycle pulse when both write command and write data are accepted.
- rd_req  in  1  read request; level, held until rd_ack.
- rd_addr  in  ADDR_W  read address.
- rd_ack  out  1  one-cycle pulse when the read command is accepted.
- rd_data  out  DATA_W  returned read data.
- rd_valid  out  1  rd_data qualifier.
- rd_underflow  out  1  sticky flag: data returned with no read outstanding.
- app_en, app_cmd[2:0], app_addr[ADDR_W], app_wdf_wren, app_wdf_end, app_wdf_data[DATA_W]  out  MIG command and write-data drive.
- app_rdy, app_wdf_rdy, app_rd_data_valid  in  1  MIG handshakes.
- app_rd_data  in  DATA_W  MIG read data.

Function
REQ-006 SHALL have the states IDLE, WR and RD.
REQ-007 SHALL NOT grant any request in IDLE while calib_done=0.
REQ-008 SHALL arbitrate in IDLE as follows:
- Only one requester eligible: grant it.
- Both eligible: grant the one not granted last (round-robin bit last_gnt).
- A read is eligible only when outstanding < MAX_RD_OUT.
REQ-009 SHALL latch the address (and, for a write, the data) on the grant cycle, then move to WR or RD on the next edge.
REQ-010 SHALL, in WR, drive:
- app_en=1 with app_cmd=3'b000.
- app_wdf_wren=1 and app_wdf_end=1 in the same cycles.
REQ-011 SHALL consider the write command accepted on app_en&app_rdy, and then drop app_en.
REQ-012 SHALL consider the write data accepted on app_wdf_wren&app_wdf_rdy, and then drop app_wdf_wren/app_wdf_end.
REQ-013 SHALL accept write command and write data independently; they may be accepted in either order or in the same cycle.
REQ-014 SHALL, in the cycle the second of the two (command, data) is accepted, pulse wr_ack and return to IDLE.
REQ-015 SHALL, in RD, drive app_en=1 with app_cmd=3'b001 until app_rdy=1; in that cycle it SHALL pulse rd_ack, increment outstanding and return to IDLE.
REQ-016 SHALL decrement outstanding on app_rd_data_valid.
REQ-017 SHALL leave outstanding unchanged when an increment and a decrement occur in the same cycle.
REQ-018 SHALL, on app_rd_data_valid with outstanding=0, hold outstanding at 0 and set rd_underflow, which stays set until reset.
REQ-019 SHALL register rd_data/rd_valid from app_rd_data/app_rd_data_valid with exactly one cycle of latency, preserving order.
REQ-020 SHALL hold app_en=0, app_wdf_wren=0 and app_cmd=3'b000 in IDLE; app_addr SHALL show the latched address.
REQ-021 SHALL take a minimum of 2 cycles from request to ack (grant cycle plus one handshake cycle); back-to-back grants SHALL have one IDLE cycle between them.
REQ-022 SHALL update last_gnt on each grant.

Reset
REQ-023 SHALL, on rst_n=0, asynchronously:
- force the state to IDLE;
- clear all outputs, outstanding and rd_underflow;
- set last_gnt=read, so a write wins the first tie.
REQ-024 SHALL abandon any transaction in flight when reset asserts; no ack is issued for it.

Structure
REQ-025 SHALL take the state encoding and CMD_WRITE=3'b000 / CMD_READ=3'b001 constants from shared package ddr2_arb_pkg.
REQ-026 SHALL implement the outstanding counter, the underflow flag and the rd_data/rd_valid register in one sub-module, ddr2_rd_tracker.

Verification
REQ-027 Tie: wr_req=rd_req=1 right after reset, calib_done=1 -> write granted first (app_cmd=000), then read (app_cmd=001).
REQ-028 Write with app_rdy=1 but app_wdf_rdy low for 3 cycles -> app_en high for 1 cycle, wren high for 4 cycles, wr_ack in the 4th cycle.
REQ-029 Five reads issued with app_rd_data_valid held low and MAX_RD_OUT=4 -> exactly 4 rd_acks; the 5th read waits until one valid returns.
REQ-030 app_rd_data_valid with data 128'hA5..A5 -> rd_valid=1 with the same data one cycle later; a valid with outstanding=0 -> rd_underflow=1.
REQ-031 Stimulus: calib_done=0 while wr_req=1 -> app_en stays 0; after calib_done rises, grant follows within 1 cycle.
REQ-032 Stimulus: reset asserted in WR -> all outputs 0 immediately, no wr_ack; the next request is served normally.
